branch_flush_ctrl: RTL and testbench

BRANCH_FLUSH_CTRL -- requirements
Module: branch_flush_ctrl

---
 rtl/branch_flush_ctrl_pkg.sv | 33 +++
 rtl/branch_flush_ctrl_if.sv | 37 +++
 rtl/branch_history_table.sv | 48 ++++
 rtl/branch_flush_ctrl.sv | 144 ++++++++++++++
 tb/tb_branch_flush_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/branch_flush_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : branch_flush_ctrl_pkg
//  Brief    : Shared encodings and helpers for the branch flush controller.
//  Revision : 1.0 - initial release
// ============================================================================
package branch_flush_ctrl_pkg;

    localparam int c_state_w = 2;
    localparam int c_drain_w = 3;
    localparam int c_cnt_w   = 16;

    typedef logic [c_state_w-1:0] fsm_state_t;

    localparam fsm_state_t c_st_idle     = 2'd0;
    localparam fsm_state_t c_st_redirect = 2'd1;
    localparam fsm_state_t c_st_drain    = 2'd2;

    localparam logic c_sel_target   = 1'b0;
    localparam logic c_sel_fallthru = 1'b1;

    // Weakly not-taken
    localparam logic [1:0] c_bht_reset = 2'b01;

    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_flush_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_flush_ctrl_if
//  Brief    : Pipeline <-> branch flush controller signal bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_flush_ctrl_if;
    import branch_flush_ctrl_pkg::*;

    logic               stall;
    logic               if_valid;
    logic [31:0]        if_pc;
    logic               predict_taken;
    logic               ex_branch;
    logic               ex_taken;
    logic               ex_pred_taken;
    logic [31:0]        ex_pc;
    logic               pc_redirect;
    logic               redirect_sel;
    logic               flush_if_id;
    logic               flush_id_ex;
    logic [c_cnt_w-1:0] mispredict_cnt;

    modport master (
        output stall, if_valid, if_pc, ex_branch, ex_taken, ex_pred_taken, ex_pc,
        input  predict_taken, pc_redirect, redirect_sel, flush_if_id, flush_id_ex,
               mispredict_cnt
    );

    modport slave (
        input  stall, if_valid, if_pc, ex_branch, ex_taken, ex_pred_taken, ex_pc,
        output predict_taken, pc_redirect, redirect_sel, flush_if_id, flush_id_ex,
               mispredict_cnt
    );

endinterface
`default_nettype wire

// File: rtl/branch_history_table.sv
`default_nettype none
// ============================================================================
//  Module   : branch_history_table
//  Brief    : Table of 2-bit saturating predictors, async read / sync update.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_history_table
    import branch_flush_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16
)
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] i_lookup_pc,
    output logic [1:0]       o_lookup_ctr,
    input  wire logic        i_upd_en,
    input  wire logic [31:0] i_upd_pc,
    input  wire logic        i_upd_taken
);

    localparam int c_idx_w = $clog2(ENTRIES);

    logic [1:0]         r_ctr [ENTRIES];
    logic [c_idx_w-1:0] w_rd_idx;
    logic [c_idx_w-1:0] w_wr_idx;
    logic               w_unused_pc;

    assign w_rd_idx = i_lookup_pc[c_idx_w+1:2];
    assign w_wr_idx = i_upd_pc[c_idx_w+1:2];
    assign w_unused_pc = &{1'b0, i_lookup_pc[31:c_idx_w+2], i_lookup_pc[1:0],
                           i_upd_pc[31:c_idx_w+2], i_upd_pc[1:0]};

    // Read comes straight from the array, so a same-index update is seen next cycle
    assign o_lookup_ctr = r_ctr[w_rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= c_bht_reset;
            end
        end else if (i_upd_en) begin
            r_ctr[w_wr_idx] <= bht_next(r_ctr[w_wr_idx], i_upd_taken);
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_flush_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_flush_ctrl
//  Brief    : Mispredict detection, PC redirect and pipeline flush sequencing.
//             Define BRANCH_PRED_EN to add the BHT-based fetch predictor.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_flush_ctrl
    import branch_flush_ctrl_pkg::*;
#(
    parameter int BHT_ENTRIES  = 16,
    parameter int DRAIN_CYCLES = 1
)
(
    input wire logic           clk,
    input wire logic           rst,
    branch_flush_ctrl_if.slave bus
);

    localparam logic [c_drain_w-1:0] c_drain_load = c_drain_w'(DRAIN_CYCLES);
    localparam logic [c_cnt_w-1:0]   c_cnt_max    = {c_cnt_w{1'b1}};

    fsm_state_t           r_state;
    fsm_state_t           w_state_nxt;
    logic [c_drain_w-1:0] r_drain_cnt;
    logic [c_drain_w-1:0] w_drain_cnt_nxt;
    logic                 r_pc_redirect;
    logic                 w_pc_redirect_nxt;
    logic                 r_redirect_sel;
    logic                 w_redirect_sel_nxt;
    logic                 r_flush_if_id;
    logic                 w_flush_if_id_nxt;
    logic                 r_flush_id_ex;
    logic                 w_flush_id_ex_nxt;
    logic [c_cnt_w-1:0]   r_mispredict_cnt;
    logic [c_cnt_w-1:0]   w_mispredict_cnt_nxt;
    logic                 w_sample;
    logic                 w_mispredict;

    // Branches seen outside IDLE are squashed bubbles and must not act
    assign w_sample = ~bus.stall & bus.ex_branch & (r_state == c_st_idle);

`ifdef BRANCH_PRED_EN
    logic [1:0] w_lookup_ctr;

    branch_history_table #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk          (clk),
        .rst          (rst),
        .i_lookup_pc  (bus.if_pc),
        .o_lookup_ctr (w_lookup_ctr),
        .i_upd_en     (w_sample),
        .i_upd_pc     (bus.ex_pc),
        .i_upd_taken  (bus.ex_taken)
    );

    assign bus.predict_taken = bus.if_valid & w_lookup_ctr[1];
    assign w_mispredict      = w_sample & (bus.ex_taken != bus.ex_pred_taken);
`else
    logic w_unused_nopred;

    assign w_unused_nopred   = &{1'b0, bus.if_valid, bus.if_pc, bus.ex_pred_taken, bus.ex_pc};
    // Static not-taken prediction: only taken branches can be wrong
    assign bus.predict_taken = 1'b0;
    assign w_mispredict      = w_sample & bus.ex_taken;
`endif

    always_comb begin
        w_state_nxt          = r_state;
        w_drain_cnt_nxt      = r_drain_cnt;
        w_redirect_sel_nxt   = r_redirect_sel;
        w_pc_redirect_nxt    = 1'b0;
        w_flush_if_id_nxt    = 1'b0;
        w_flush_id_ex_nxt    = 1'b0;
        w_mispredict_cnt_nxt = r_mispredict_cnt;

        case (r_state)
            c_st_idle: begin
                if (w_mispredict) begin
                    w_state_nxt        = c_st_redirect;
                    w_redirect_sel_nxt = bus.ex_taken ? c_sel_target : c_sel_fallthru;
                    w_pc_redirect_nxt  = 1'b1;
                    w_flush_if_id_nxt  = 1'b1;
                    w_flush_id_ex_nxt  = 1'b1;
                    if (r_mispredict_cnt != c_cnt_max) begin
                        w_mispredict_cnt_nxt = r_mispredict_cnt + 1'b1;
                    end
                end
            end
            c_st_redirect: begin
                if (c_drain_load != '0) begin
                    w_state_nxt       = c_st_drain;
                    w_drain_cnt_nxt   = c_drain_load;
                    w_flush_if_id_nxt = 1'b1;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_drain: begin
                // Counter holds the drain cycles left including the current one
                if (r_drain_cnt <= c_drain_w'(1)) begin
                    w_state_nxt     = c_st_idle;
                    w_drain_cnt_nxt = '0;
                end else begin
                    w_drain_cnt_nxt   = r_drain_cnt - 1'b1;
                    w_flush_if_id_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = c_st_idle;
                w_drain_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= c_st_idle;
            r_drain_cnt      <= '0;
            r_pc_redirect    <= 1'b0;
            r_redirect_sel   <= 1'b0;
            r_flush_if_id    <= 1'b0;
            r_flush_id_ex    <= 1'b0;
            r_mispredict_cnt <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_drain_cnt      <= w_drain_cnt_nxt;
            r_pc_redirect    <= w_pc_redirect_nxt;
            r_redirect_sel   <= w_redirect_sel_nxt;
            r_flush_if_id    <= w_flush_if_id_nxt;
            r_flush_id_ex    <= w_flush_id_ex_nxt;
            r_mispredict_cnt <= w_mispredict_cnt_nxt;
        end
    end

    assign bus.pc_redirect    = r_pc_redirect;
    assign bus.redirect_sel   = r_redirect_sel;
    assign bus.flush_if_id    = r_flush_if_id;
    assign bus.flush_id_ex    = r_flush_id_ex;
    assign bus.mispredict_cnt = r_mispredict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_flush_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_flush_ctrl
//  Brief    : Directed scoreboard bench for branch_flush_ctrl (DRAIN_CYCLES=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_flush_ctrl;

    localparam int c_drain = 3;
`ifdef BRANCH_PRED_EN
    localparam logic [15:0] c_cnt_pre = 16'd2;
`else
    localparam logic [15:0] c_cnt_pre = 16'd1;
`endif

    logic clk = 1'b0;
    logic rst;

    branch_flush_ctrl_if bus();

    branch_flush_ctrl #(
        .BHT_ENTRIES  (16),
        .DRAIN_CYCLES (c_drain)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        red;
        logic        sel;
        logic        fif;
        logic        fie;
        logic [15:0] cnt;
        logic        pred;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic step(input string nm, input logic r, st, iv, input logic [31:0] ipc,
                        input logic br, tk, pt, input logic [31:0] pc,
                        input logic e_red, e_sel, e_fif, e_fie,
                        input logic [15:0] e_cnt, input logic e_pred);
        exp_t e;
        @(negedge clk);
        #2;
        rst               = r;
        bus.stall         = st;
        bus.if_valid      = iv;
        bus.if_pc         = ipc;
        bus.ex_branch     = br;
        bus.ex_taken      = tk;
        bus.ex_pred_taken = pt;
        bus.ex_pc         = pc;
        e.nm   = nm;
        e.red  = e_red;
        e.sel  = e_sel;
        e.fif  = e_fif;
        e.fie  = e_fie;
        e.cnt  = e_cnt;
        e.pred = e_pred;
        q.push_back(e);
    endtask

    initial begin
        forever begin
            exp_t e;
            logic ok;
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                ok = (bus.pc_redirect === e.red) && (bus.flush_if_id === e.fif) &&
                     (bus.flush_id_ex === e.fie) && (bus.mispredict_cnt === e.cnt) &&
                     (bus.predict_taken === e.pred) &&
                     (!e.red || (bus.redirect_sel === e.sel));
                n_checks++;
                if (ok) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got red=%b sel=%b fif=%b fie=%b cnt=%h pred=%b, want red=%b sel=%b fif=%b fie=%b cnt=%h pred=%b",
                             e.nm, bus.pc_redirect, bus.redirect_sel, bus.flush_if_id,
                             bus.flush_id_ex, bus.mispredict_cnt, bus.predict_taken,
                             e.red, e.sel, e.fif, e.fie, e.cnt, e.pred);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        bus.stall         = 1'b0;
        bus.if_valid      = 1'b0;
        bus.if_pc         = 32'h0;
        bus.ex_branch     = 1'b0;
        bus.ex_taken      = 1'b0;
        bus.ex_pred_taken = 1'b0;
        bus.ex_pc         = 32'h0;

        //   name               rst st iv if_pc      br tk pt ex_pc       red sel fif fie cnt       pred
        step("reset",           1, 0, 0, 32'h0,     0, 0, 0, 32'h0,      0, 0, 0, 0, 16'd0,    0);
        step("reset_priority",  1, 0, 0, 32'h0,     1, 1, 0, 32'h104,    0, 0, 0, 0, 16'd0,    0);
        step("idle",            0, 0, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 0, 0, 16'd0,    0);
        step("not_taken",       0, 0, 0, 32'h0,     1, 0, 0, 32'h104,    0, 0, 0, 0, 16'd0,    0);
        step("stall_gate",      0, 1, 0, 32'h0,     1, 1, 0, 32'h104,    0, 0, 0, 0, 16'd0,    0);
        step("mispredict",      0, 0, 0, 32'h0,     1, 1, 0, 32'h104,    1, 0, 1, 1, 16'd1,    0);
        step("drain1",          0, 0, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 1, 0, 16'd1,    0);
        step("drain2_ignored",  0, 0, 0, 32'h0,     1, 1, 0, 32'h104,    0, 0, 1, 0, 16'd1,    0);
        step("drain3_stall",    0, 1, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 1, 0, 16'd1,    0);
        step("drain_done",      0, 0, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 0, 0, 16'd1,    0);
`ifdef BRANCH_PRED_EN
        step("bht_t1",          0, 0, 1, 32'h40,    1, 1, 1, 32'h40,     0, 0, 0, 0, 16'd1,    1);
        step("bht_t2",          0, 0, 1, 32'h40,    1, 1, 1, 32'h40,     0, 0, 0, 0, 16'd1,    1);
        step("bht_n1",          0, 0, 1, 32'h40,    1, 0, 0, 32'h40,     0, 0, 0, 0, 16'd1,    1);
        step("bht_n2",          0, 0, 1, 32'h40,    1, 0, 0, 32'h40,     0, 0, 0, 0, 16'd1,    0);
        step("bht_n3",          0, 0, 1, 32'h40,    1, 0, 0, 32'h40,     0, 0, 0, 0, 16'd1,    0);
        step("mp_fallthru",     0, 0, 0, 32'h0,     1, 0, 1, 32'h104,    1, 1, 1, 1, 16'd2,    0);
        step("ft_drain1",       0, 0, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 1, 0, 16'd2,    0);
        step("ft_drain2",       0, 0, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 1, 0, 16'd2,    0);
        step("ft_drain3",       0, 0, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 1, 0, 16'd2,    0);
        step("ft_idle",         0, 0, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 0, 0, 16'd2,    0);
`endif
        step("mispredict2",     0, 0, 0, 32'h0,     1, 1, 0, 32'h104,    1, 0, 1, 1, 16'(c_cnt_pre + 16'd1), 0);
        step("rst_in_redirect", 1, 0, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 0, 0, 16'd0,    0);
        step("post_rst",        0, 0, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 0, 0, 16'd0,    0);
        step("post_rst2",       0, 0, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 0, 0, 16'd0,    0);
`ifdef BRANCH_PRED_EN
        step("bht_after_rst",   0, 0, 1, 32'h40,    1, 1, 1, 32'h40,     0, 0, 0, 0, 16'd0,    1);
`endif
        step("saturate",        0, 0, 0, 32'h0,     1, 1, 0, 32'h104,    1, 0, 1, 1, 16'hFFFF, 0);
        force dut.r_mispredict_cnt = 16'hFFFF;
        #1;
        release dut.r_mispredict_cnt;
        step("sat_drain1",      0, 0, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 1, 0, 16'hFFFF, 0);
        step("sat_drain2",      0, 0, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 1, 0, 16'hFFFF, 0);
        step("sat_drain3",      0, 0, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 1, 0, 16'hFFFF, 0);
        step("sat_idle",        0, 0, 0, 32'h0,     0, 0, 0, 32'h104,    0, 0, 0, 0, 16'hFFFF, 0);

        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL queue_drained: got %0d pending entries, want 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
